// File: rtl/fft4_output_serializer_if.sv
// Bundles the frame-in and beat-out handshakes of the 4-point FFT output serializer.
//   master : the side that produces frames and consumes beats
//            (drives in_valid, y*_re/y*_im and out_ready)
//   slave  : the serializer itself
//            (drives in_ready and out_valid/out_re/out_im/out_idx/out_last)
// Each DATA_W field is one two's complement component of a complex sample.
interface fft4_output_serializer_if #(
  parameter int unsigned DATA_W = 16
);
  // Frame input side
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] y0_re;
  logic [DATA_W-1:0] y1_re;
  logic [DATA_W-1:0] y2_re;
  logic [DATA_W-1:0] y3_re;
  logic [DATA_W-1:0] y0_im;
  logic [DATA_W-1:0] y1_im;
  logic [DATA_W-1:0] y2_im;
  logic [DATA_W-1:0] y3_im;

  // Beat output side
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_re;
  logic [DATA_W-1:0] out_im;
  logic [1:0]        out_idx;
  logic              out_last;

  modport master (
    output in_valid,
    output y0_re, y1_re, y2_re, y3_re,
    output y0_im, y1_im, y2_im, y3_im,
    output out_ready,
    input  in_ready,
    input  out_valid, out_re, out_im, out_idx, out_last
  );

  modport slave (
    input  in_valid,
    input  y0_re, y1_re, y2_re, y3_re,
    input  y0_im, y1_im, y2_im, y3_im,
    input  out_ready,
    output in_ready,
    output out_valid, out_re, out_im, out_idx, out_last
  );
endinterface

// File: rtl/fft4_output_serializer.sv
// Downstream stage of the 4-point DIF FFT core. Captures one parallel frame (y0..y3, complex)
// into one of two ping-pong banks and streams it out one complex sample per beat.
//
// Ports
//   clk    : clock, all state updates on the rising edge
//   reset  : asynchronous, active-low; discards all buffered frames and clears the banks
//   bus    : fft4_output_serializer_if.slave
//            in_valid/in_ready + y*_re/y*_im  frame input (accepted when both high)
//            out_valid/out_ready + out_re/out_im/out_idx/out_last  beat output
//
// Configuration macro: FFT4_REORDER_EN
//   defined   : frame is bit-reversed DIF output; words are read y0, y2, y1, y3
//   undefined : words are read in port order y0, y1, y2, y3
//   out_idx is 0..3 in both cases; ports, latency and handshake are unchanged.
module fft4_output_serializer #(
  parameter int unsigned DATA_W = 16
) (
  input logic                      clk,
  input logic                      reset,
  fft4_output_serializer_if.slave  bus
);

  // State is the number of frames held in the banks
  typedef enum logic [1:0] {
    StEmpty = 2'd0,
    StOne   = 2'd1,
    StFull  = 2'd2
  } state_e;

  state_e state_q, state_d;

  logic       wr_bank_q, wr_bank_d;
  logic       rd_bank_q, rd_bank_d;
  logic [1:0] beat_cnt_q, beat_cnt_d;

  logic [DATA_W-1:0] re_q [2][4];
  logic [DATA_W-1:0] re_d [2][4];
  logic [DATA_W-1:0] im_q [2][4];
  logic [DATA_W-1:0] im_d [2][4];

  logic       in_ready;
  logic       out_valid;
  logic       out_last;
  logic       push;
  logic       beat_acc;
  logic       frame_done;
  logic [1:0] rd_word;

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= StEmpty;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next state
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StEmpty: begin
        if (push) state_d = StOne;
      end
      StOne: begin
        // Push together with frame completion leaves the count unchanged
        if (push && !frame_done)      state_d = StFull;
        else if (frame_done && !push) state_d = StEmpty;
      end
      StFull: begin
        if (frame_done) state_d = StOne;
      end
      default: state_d = StEmpty;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: outputs, decoded from registers only (no input-to-output path)
  // ---------------------------------------------------------------------------
  always_comb begin
    in_ready  = (state_q != StFull);
    out_valid = (state_q != StEmpty);
    out_last  = out_valid && (beat_cnt_q == 2'd3);
  end

  // Handshake events
  always_comb begin
    push       = bus.in_valid && in_ready;
    beat_acc   = out_valid && bus.out_ready;
    frame_done = beat_acc && out_last;
  end

  // ---------------------------------------------------------------------------
  // Datapath next state: bank write, bank pointers, beat counter
  // ---------------------------------------------------------------------------
  always_comb begin
    re_d       = re_q;
    im_d       = im_q;
    wr_bank_d  = wr_bank_q;
    rd_bank_d  = rd_bank_q;
    beat_cnt_d = beat_cnt_q;

    if (push) begin
      re_d[wr_bank_q][0] = bus.y0_re;
      re_d[wr_bank_q][1] = bus.y1_re;
      re_d[wr_bank_q][2] = bus.y2_re;
      re_d[wr_bank_q][3] = bus.y3_re;
      im_d[wr_bank_q][0] = bus.y0_im;
      im_d[wr_bank_q][1] = bus.y1_im;
      im_d[wr_bank_q][2] = bus.y2_im;
      im_d[wr_bank_q][3] = bus.y3_im;
      wr_bank_d          = ~wr_bank_q;
    end

    if (beat_acc) begin
      beat_cnt_d = beat_cnt_q + 2'd1;
      // Wrapping past the last beat frees the bank and moves to the other one
      if (beat_cnt_q == 2'd3) begin
        rd_bank_d = ~rd_bank_q;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_bank_q  <= 1'b0;
      rd_bank_q  <= 1'b0;
      beat_cnt_q <= 2'd0;
      for (int b = 0; b < 2; b++) begin
        for (int w = 0; w < 4; w++) begin
          re_q[b][w] <= '0;
          im_q[b][w] <= '0;
        end
      end
    end else begin
      wr_bank_q  <= wr_bank_d;
      rd_bank_q  <= rd_bank_d;
      beat_cnt_q <= beat_cnt_d;
      re_q       <= re_d;
      im_q       <= im_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Read mux: unregistered, so a stalled beat holds as long as its registers do
  // ---------------------------------------------------------------------------
`ifdef FFT4_REORDER_EN
  // Bit-reversed frame: beat k reads word bitrev(k), giving y0, y2, y1, y3
  assign rd_word = {beat_cnt_q[0], beat_cnt_q[1]};
`else
  assign rd_word = beat_cnt_q;
`endif

  always_comb begin
    bus.in_ready  = in_ready;
    bus.out_valid = out_valid;
    bus.out_last  = out_last;
    bus.out_idx   = beat_cnt_q;
    bus.out_re    = re_q[rd_bank_q][rd_word];
    bus.out_im    = im_q[rd_bank_q][rd_word];
  end

endmodule

// File: tb/tb_fft4_output_serializer.sv
// Self-checking bench for fft4_output_serializer. A queue of expected beats models the
// serializer: each accepted frame appends its four beats, each accepted beat pops one.
module tb_fft4_output_serializer;

  localparam int unsigned DW = 16;

  typedef struct packed {
    logic [DW-1:0] re;
    logic [DW-1:0] im;
    logic [1:0]    idx;
    logic          last;
  } beat_t;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  beat_t exp_q[$];

  always #5 clk = ~clk;

  fft4_output_serializer_if #(.DATA_W(DW)) bus ();

  fft4_output_serializer #(.DATA_W(DW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // Frame word emitted on beat b
  function automatic int src_word(input int b);
`ifdef FFT4_REORDER_EN
    return (b % 2) * 2 + (b / 2);
`else
    return b;
`endif
  endfunction

  function automatic int frames_held();
    return (exp_q.size() + 3) / 4;
  endfunction

  function automatic logic [63:0] rnd64();
    return {$urandom, $urandom};
  endfunction

  // One clock cycle: drive inputs after the falling edge, check outputs, update the model
  task automatic cycle(input logic iv, input logic [63:0] fre, input logic [63:0] fim,
                       input logic ordy, output logic pushed);
    logic  exp_rdy, exp_vld, pop;
    beat_t nb;
    @(negedge clk);
    bus.in_valid  = iv;
    bus.y0_re     = fre[15:0];
    bus.y1_re     = fre[31:16];
    bus.y2_re     = fre[47:32];
    bus.y3_re     = fre[63:48];
    bus.y0_im     = fim[15:0];
    bus.y1_im     = fim[31:16];
    bus.y2_im     = fim[47:32];
    bus.y3_im     = fim[63:48];
    bus.out_ready = ordy;
    #1;
    exp_rdy = (frames_held() < 2);
    exp_vld = (exp_q.size() > 0);
    check("in_ready", {31'd0, bus.in_ready}, {31'd0, exp_rdy});
    check("out_valid", {31'd0, bus.out_valid}, {31'd0, exp_vld});
    if (exp_vld) begin
      check("out_re", {16'd0, bus.out_re}, {16'd0, exp_q[0].re});
      check("out_im", {16'd0, bus.out_im}, {16'd0, exp_q[0].im});
      check("out_idx", {30'd0, bus.out_idx}, {30'd0, exp_q[0].idx});
      check("out_last", {31'd0, bus.out_last}, {31'd0, exp_q[0].last});
    end else begin
      check("out_last_idle", {31'd0, bus.out_last}, 32'd0);
    end
    pushed = iv && exp_rdy;
    pop    = exp_vld && ordy;
    @(posedge clk);
    if (pop) void'(exp_q.pop_front());
    if (pushed) begin
      for (int b = 0; b < 4; b++) begin
        nb.re   = fre[16*src_word(b) +: 16];
        nb.im   = fim[16*src_word(b) +: 16];
        nb.idx  = 2'(b);
        nb.last = (b == 3);
        exp_q.push_back(nb);
      end
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_out_valid"}, {31'd0, bus.out_valid}, 32'd0);
    check({tag, "_out_last"}, {31'd0, bus.out_last}, 32'd0);
    check({tag, "_out_idx"}, {30'd0, bus.out_idx}, 32'd0);
    check({tag, "_out_re"}, {16'd0, bus.out_re}, 32'd0);
    check({tag, "_out_im"}, {16'd0, bus.out_im}, 32'd0);
    check({tag, "_in_ready"}, {31'd0, bus.in_ready}, 32'd1);
  endtask

  initial begin
    logic        p;
    logic        taken;
    logic [63:0] f1, f2, f3;

    // 1. Reset, then release
    reset         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.y0_re = '0; bus.y1_re = '0; bus.y2_re = '0; bus.y3_re = '0;
    bus.y0_im = '0; bus.y1_im = '0; bus.y2_im = '0; bus.y3_im = '0;
    #1;
    check_reset_outputs("rst");
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    cycle(1'b0, 64'd0, 64'd0, 1'b1, p);

    // 2. Single frame re = 10, 20, 30, 40, im = 0
    cycle(1'b1, {16'd40, 16'd30, 16'd20, 16'd10}, 64'd0, 1'b1, p);
    repeat (5) cycle(1'b0, 64'd0, 64'd0, 1'b1, p);

    // 3. Sink stalled, three frames offered; third accepted only after frame 1 drains
    f1 = rnd64(); f2 = rnd64(); f3 = rnd64();
    cycle(1'b1, f1, rnd64(), 1'b0, p);
    cycle(1'b1, f2, rnd64(), 1'b0, p);
    repeat (3) cycle(1'b1, f3, 64'd0, 1'b0, p);
    taken = 1'b0;
    repeat (14) begin
      cycle(!taken, f3, 64'd0, 1'b1, p);
      if (p) taken = 1'b1;
    end
    check("third_frame_taken", {31'd0, taken}, 32'd1);

    // 4. Toggling out_ready with extreme values
    cycle(1'b1, {rnd64() >> 16, 16'h8000}, {rnd64() >> 16, 16'h7FFF}, 1'b0, p);
    for (int i = 0; i < 10; i++) cycle(1'b0, 64'd0, 64'd0, (i % 2) == 0, p);

    // 5. Back-to-back frames
    repeat (16) cycle(1'b1, rnd64(), rnd64(), 1'b1, p);
    repeat (10) cycle(1'b0, 64'd0, 64'd0, 1'b1, p);

    // 6. Reset after beat 2 of a frame with a second frame buffered
    cycle(1'b1, rnd64(), rnd64(), 1'b0, p);
    cycle(1'b1, rnd64(), rnd64(), 1'b1, p);
    cycle(1'b0, 64'd0, 64'd0, 1'b1, p);
    #3;
    reset = 1'b0;
    #1;
    check_reset_outputs("midrst");
    exp_q.delete();
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    repeat (4) cycle(1'b0, 64'd0, 64'd0, 1'b1, p);

    // Random traffic
    repeat (300) begin
      cycle($urandom_range(0, 2) != 0, rnd64(), rnd64(), $urandom_range(0, 2) != 0, p);
    end
    repeat (12) cycle(1'b0, 64'd0, 64'd0, 1'b1, p);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
